cache_mem_arbiter: RTL

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
//----------------------------------------------------------------------------
// Module   : cache_mem_arbiter
// Purpose  : Two-way round-robin arbiter that shares one memory port between
//            the I-cache and D-cache, with burst ownership and beat counting.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module cache_mem_arbiter #(
  parameter int DATA_BITS = 32,
  parameter int TYPE_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  // I-cache side
  input  logic                 i_req,
  input  logic                 i_write,
  input  logic [DATA_BITS-1:0] i_addr,
  input  logic [DATA_BITS-1:0] i_in,
  input  logic [TYPE_BITS-1:0] i_type,
  output logic [DATA_BITS-1:0] i_out,
  output logic                 i_wait,
  // D-cache side
  input  logic                 d_req,
  input  logic                 d_write,
  input  logic [DATA_BITS-1:0] d_addr,
  input  logic [DATA_BITS-1:0] d_in,
  input  logic [TYPE_BITS-1:0] d_type,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 d_wait,
  // Shared memory port
  output logic                 mem_req,
  output logic                 mem_write,
  output logic [DATA_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_in,
  output logic [TYPE_BITS-1:0] mem_type,
  input  logic [DATA_BITS-1:0] mem_out,
  input  logic                 mem_wait,
  // Ownership status
  output logic [1:0]           gnt,
  output logic [3:0]           beat_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } state_t;

  localparam logic       c_LAST_I   = 1'b0;
  localparam logic       c_LAST_D   = 1'b1;
  localparam logic [3:0] c_BEAT_MAX = 4'd15;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_last_gnt;
  logic [1:0] r_gnt;
  logic [3:0] r_beat_cnt;
  logic       w_entry;
  logic       w_beat;

  // Ownership is only released when the owner drops its request.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_req && d_req) begin
          w_next_state = (r_last_gnt == c_LAST_I) ? ST_GNT_D : ST_GNT_I;
        end else if (i_req) begin
          w_next_state = ST_GNT_I;
        end else if (d_req) begin
          w_next_state = ST_GNT_D;
        end
      end
      ST_GNT_I: begin
        if (!i_req) begin
          w_next_state = d_req ? ST_GNT_D : ST_IDLE;
        end
      end
      ST_GNT_D: begin
        if (!d_req) begin
          w_next_state = i_req ? ST_GNT_I : ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_entry = (w_next_state != r_state) && (w_next_state != ST_IDLE);
  assign w_beat  = (r_state != ST_IDLE) && mem_req && !mem_wait;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= c_LAST_I;
      r_gnt      <= 2'b00;
      r_beat_cnt <= 4'd0;
    end else begin
      r_state <= w_next_state;
      case (w_next_state)
        ST_GNT_I: r_gnt <= 2'b01;
        ST_GNT_D: r_gnt <= 2'b10;
        default:  r_gnt <= 2'b00;
      endcase
      if (w_entry) begin
        r_last_gnt <= (w_next_state == ST_GNT_D) ? c_LAST_D : c_LAST_I;
        r_beat_cnt <= 4'd0;
      end else if (w_beat && (r_beat_cnt != c_BEAT_MAX)) begin
        r_beat_cnt <= r_beat_cnt + 4'd1;
      end
    end
  end

  // Non-owners see zero data and stall for as long as they keep requesting.
  always_comb begin
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_in    = '0;
    mem_type  = '0;
    i_out     = '0;
    d_out     = '0;
    i_wait    = i_req;
    d_wait    = d_req;
    case (r_state)
      ST_GNT_I: begin
        mem_req   = i_req;
        mem_write = i_write;
        mem_addr  = i_addr;
        mem_in    = i_in;
        mem_type  = i_type;
        i_out     = mem_out;
        i_wait    = mem_wait;
      end
      ST_GNT_D: begin
        mem_req   = d_req;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_in    = d_in;
        mem_type  = d_type;
        d_out     = mem_out;
        d_wait    = mem_wait;
      end
      default: ;
    endcase
  end

  assign gnt      = r_gnt;
  assign beat_cnt = r_beat_cnt;

endmodule

`default_nettype wire
